// File: rtl/muldiv_iter_unit_if.sv
// Issue/result bundle between the pipeline (master) and muldiv_iter_unit (slave).
interface muldiv_iter_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter_unit.sv
// HI/LO multiply/divide unit: delayed multiply commit, restoring divider, cancel.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module muldiv_iter_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input logic               clk,
  input logic               reset,
  muldiv_iter_unit_if.slave bus
);
  localparam int CMAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3,
                         OP_DIVU  = 4'd4, OP_MTHI  = 4'd5, OP_MTLO  = 4'd6;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     dvs_q, quo_q, rem_q;
  logic                 qneg_q, rneg_q, dz_q;

  logic                 is_mul, is_div, is_sgn, is_mthi, is_mtlo, accept;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, mul_res;
  logic [WIDTH-1:0]     a_abs, b_abs, q_fin, r_fin;
  logic [WIDTH:0]       r_sh, diff;

`ifdef MULDIV_MADD_EN
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;
  acc_e acc_d, acc_q;
`endif

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_d   = ACC_NONE;
`endif
    case (bus.op)
      OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MTHI:  is_mthi = 1'b1;
      OP_MTLO:  is_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      4'd7:     begin is_mul = 1'b1; is_sgn = 1'b1; acc_d = ACC_ADD; end
      4'd8:     begin is_mul = 1'b1; acc_d = ACC_ADD; end
      4'd9:     begin is_mul = 1'b1; is_sgn = 1'b1; acc_d = ACC_SUB; end
      4'd10:    begin is_mul = 1'b1; acc_d = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  assign accept = bus.start & ~busy_q & ~bus.cancel;

  // Sign/zero-extend to 2*WIDTH so one unsigned multiply covers both flavours.
  assign a_ext = is_sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign b_ext = is_sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign prod  = a_ext * b_ext;

  assign a_abs = (is_sgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs = (is_sgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Restoring step: remainder stays below the divisor, so WIDTH bits hold it.
  assign r_sh  = {rem_q, quo_q[WIDTH-1]};
  assign diff  = r_sh - {1'b0, dvs_q};
  assign q_fin = qneg_q ? -quo_q : quo_q;
  assign r_fin = rneg_q ? -rem_q : rem_q;

`ifdef MULDIV_MADD_EN
  always_comb begin
    case (acc_q)
      ACC_ADD: mul_res = {hi_q, lo_q} + prod_q;
      ACC_SUB: mul_res = {hi_q, lo_q} - prod_q;
      default: mul_res = prod_q;
    endcase
  end
`else
  assign mul_res = prod_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.cancel) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            if (is_mthi) hi_q <= bus.a;
            if (is_mtlo) lo_q <= bus.a;
            if (is_mul) begin
              prod_q  <= prod;
              cnt_q   <= CW'(MULT_CYCLES);
              state_q <= MUL_WAIT;
              busy_q  <= 1'b1;
`ifdef MULDIV_MADD_EN
              acc_q   <= acc_d;
`endif
            end
            if (is_div) begin
              dvs_q   <= b_abs;
              quo_q   <= a_abs;
              rem_q   <= '0;
              qneg_q  <= is_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rneg_q  <= is_sgn & bus.a[WIDTH-1];
              dz_q    <= (bus.b == '0);
              cnt_q   <= CW'(WIDTH);
              state_q <= (bus.b == '0) ? DIV_FIX : DIV_RUN;
              busy_q  <= 1'b1;
            end
          end
          MUL_WAIT: begin
            if (cnt_q == CW'(1)) begin
              {hi_q, lo_q} <= mul_res;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
            cnt_q <= cnt_q - CW'(1);
          end
          DIV_RUN: begin
            if (!diff[WIDTH]) begin
              rem_q <= diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= r_sh[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CW'(1)) state_q <= DIV_FIX;
            cnt_q <= cnt_q - CW'(1);
          end
          DIV_FIX: begin
            if (!dz_q) begin
              lo_q   <= q_fin;
              hi_q   <= r_fin;
              done_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed vector table plus hand sequences for cancel, reset and busy corner cases.
module tb_muldiv_iter_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_iter_unit_if #(.WIDTH(32)) bus ();
  muldiv_iter_unit #(.WIDTH(32), .MULT_CYCLES(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc, dn;
  } vec_t;

  vec_t tbl[$];
  int nchk = 0, nerr = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                              input int cyc, dn);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, y);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Counts busy cycles after the issue edge (bounded) and done pulses, incl. one trailing edge.
  task automatic drain(output int cyc, output int dn);
    cyc = 0; dn = 0;
    while (bus.busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) dn++;
    end
    @(posedge clk); #1;
    if (bus.done) dn++;
  endtask

  initial begin
    int cyc, dn;
    logic [31:0] phi, plo;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    reset = 1'b1;
    edges(2);
    @(negedge clk); reset = 1'b0;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);

    tbl.push_back(mk(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1));
    tbl.push_back(mk(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, 1));
    tbl.push_back(mk(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1));
    tbl.push_back(mk(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1));
    tbl.push_back(mk(4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1));
    tbl.push_back(mk(4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 33, 1));
    tbl.push_back(mk(4'd5, 32'h11111111, 32'd0, 32'h11111111, 32'd3, 0, 0));
    tbl.push_back(mk(4'd6, 32'h22222222, 32'd0, 32'h11111111, 32'h22222222, 0, 0));
    tbl.push_back(mk(4'd4, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1, 0));
    tbl.push_back(mk(4'd3, 32'hFFFFFFF9, 32'd0, 32'h11111111, 32'h22222222, 1, 0));
    tbl.push_back(mk(4'd0, 32'd9, 32'd9, 32'h11111111, 32'h22222222, 0, 0));
    tbl.push_back(mk(4'd11, 32'd9, 32'd9, 32'h11111111, 32'h22222222, 0, 0));
    tbl.push_back(mk(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1));
    tbl.push_back(mk(4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 5, 1));
    tbl.push_back(mk(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 5, 1));
    tbl.push_back(mk(4'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 33, 1));
`ifdef MULDIV_MADD_EN
    tbl.push_back(mk(4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5, 1));
    tbl.push_back(mk(4'd9, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, 5, 1));
    tbl.push_back(mk(4'd10, 32'd1, 32'd1, 32'd0, 32'hFFFFFFF9, 5, 1));
    tbl.push_back(mk(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFF8, 5, 1));
`else
    tbl.push_back(mk(4'd7, 32'd5, 32'd6, 32'd0, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(4'd10, 32'd5, 32'd6, 32'd0, 32'hFFFFFFFF, 0, 0));
`endif

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      drain(cyc, dn);
      chk($sformatf("vec%0d busy_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
      chk($sformatf("vec%0d done_pulses", i), 64'(dn), 64'(tbl[i].dn));
      chk($sformatf("vec%0d hi", i), 64'(bus.hi), 64'(tbl[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(bus.lo), 64'(tbl[i].lo));
    end

    issue(4'd5, 32'hAAAA5555, 32'd0);
    issue(4'd6, 32'h12345678, 32'd0);
    phi = 32'hAAAA5555; plo = 32'h12345678;

    // Cancel mid-divide at cycle 10.
    issue(4'd4, 32'd100, 32'd7);
    edges(9);
    chk("cancel pre busy", 64'(bus.busy), 64'd1);
    @(negedge clk); bus.cancel = 1'b1;
    @(posedge clk); #1;
    chk("cancel busy", 64'(bus.busy), 64'd0);
    chk("cancel done", 64'(bus.done), 64'd0);
    @(negedge clk); bus.cancel = 1'b0;
    edges(40);
    chk("cancel hi", 64'(bus.hi), 64'(phi));
    chk("cancel lo", 64'(bus.lo), 64'(plo));

    // Cancel coinciding with the multiply commit edge.
    issue(4'd1, 32'd3, 32'd4);
    edges(4);
    chk("cancel commit pre busy", 64'(bus.busy), 64'd1);
    @(negedge clk); bus.cancel = 1'b1;
    @(posedge clk); #1;
    chk("cancel commit busy", 64'(bus.busy), 64'd0);
    chk("cancel commit done", 64'(bus.done), 64'd0);
    chk("cancel commit lo", 64'(bus.lo), 64'(plo));
    chk("cancel commit hi", 64'(bus.hi), 64'(phi));

    // Start together with cancel is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd5; bus.a = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start+cancel hi", 64'(bus.hi), 64'(phi));
    chk("start+cancel busy", 64'(bus.busy), 64'd0);
    @(negedge clk); bus.cancel = 1'b0;

    // Start while busy is ignored, not queued.
    issue(4'd2, 32'd2, 32'd3);
    issue(4'd4, 32'd100, 32'd7);
    drain(cyc, dn);
    chk("busy-start cycles", 64'(cyc), 64'd4);
    chk("busy-start done", 64'(dn), 64'd1);
    chk("busy-start lo", 64'(bus.lo), 64'd6);
    chk("busy-start hi", 64'(bus.hi), 64'd0);
    chk("busy-start no queue", 64'(bus.busy), 64'd0);

    // Reset mid-divide at cycle 20, then a clean multiply.
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    edges(19);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst-mid busy", 64'(bus.busy), 64'd0);
    chk("rst-mid hi", 64'(bus.hi), 64'd0);
    chk("rst-mid lo", 64'(bus.lo), 64'd0);
    @(negedge clk); reset = 1'b0;
    issue(4'd1, 32'd3, 32'd4);
    drain(cyc, dn);
    chk("post-rst cycles", 64'(cyc), 64'd5);
    chk("post-rst done", 64'(dn), 64'd1);
    chk("post-rst lo", 64'(bus.lo), 64'd12);
    chk("post-rst hi", 64'(bus.hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
